mem_bist_ctrl: RTL and testbench

//   Initiator for the 1K x 8 memory port (en / wr_rd / addr / wr_data / rd_data).
//   On a start pulse, writes a generated pattern over an address window, reads it back,

---
 rtl/mem_bist_pkg.sv | 20 ++
 rtl/mem_bist_pattern.sv | 27 ++
 rtl/mem_bist_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types and defaults for the memory BIST initiator: FSM states,
// pattern mode codes and the default memory geometry.
package mem_bist_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } bist_state_t;

  localparam logic [1:0] MODE_CONST   = 2'd0;
  localparam logic [1:0] MODE_INCR    = 2'd1;
  localparam logic [1:0] MODE_ADDR    = 2'd2;
  localparam logic [1:0] MODE_CHECKER = 2'd3;

endpackage

// File: rtl/mem_bist_pattern.sv
// Combinational pattern generator: data word for a given run index and address.
// Shared by the write path and the expected-data path of the read phase.
module mem_bist_pattern
  import mem_bist_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic [1:0]    mode,
  input  logic [DW-1:0] seed,
  input  logic [DW-1:0] idx,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] pat
);

  always_comb begin
    pat = seed;
    case (mode)
      MODE_CONST:   pat = seed;
      MODE_INCR:    pat = seed + idx;
      MODE_ADDR:    pat = DW'(addr) ^ seed;
      MODE_CHECKER: pat = idx[0] ? ~seed : seed;
      default:      pat = seed;
    endcase
  end

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST initiator: writes a pattern over an address window, reads it back,
// compares each word one cycle after the read and reports pass / error count / first failing address.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] seed,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   err_count,
  output logic [AW-1:0] first_err_addr,
  output logic          mem_en,
  output logic          mem_wr_rd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_data,
  input  logic [DW-1:0] mem_rd_data,
  output bist_state_t   dbg_state
);

  localparam logic [AW:0] ONE_I = (AW+1)'(1);

  bist_state_t   state_q, state_d;
  logic [AW:0]   idx_q, idx_d, len_q, len_d, nxt_i;
  logic [AW-1:0] base_q, base_d, sel_base, nxt_addr;
  logic [1:0]    mode_q, mode_d, sel_mode;
  logic [DW-1:0] seed_q, seed_d, sel_seed, nxt_pat;
  logic          zero_pend_q, zero_pend_d;
  logic [DW-1:0] cur_exp_q, cur_exp_d, cmp_exp_q, cmp_exp_d;
  logic          cmp_vld_q, cmp_vld_d;
  logic [AW-1:0] cmp_addr_q, cmp_addr_d;
  logic          busy_d, done_d, pass_d;
  logic [AW:0]   err_d, err_upd;
  logic [AW-1:0] first_d, first_upd;
  logic          mem_en_d, mem_wr_rd_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wr_data_d;
  logic          idx_last, mismatch;

  assign dbg_state = state_q;
  assign idx_last  = (idx_q == len_q - ONE_I);

  // In IDLE the run parameters come straight from the ports so the first
  // access can be presented on the edge that accepts start.
  assign sel_base = (state_q == IDLE) ? base_addr : base_q;
  assign sel_mode = (state_q == IDLE) ? mode      : mode_q;
  assign sel_seed = (state_q == IDLE) ? seed      : seed_q;

  always_comb begin
    nxt_i = idx_q + ONE_I;
    if (state_q == IDLE || (state_q == WRITE && idx_last)) nxt_i = '0;
  end

  assign nxt_addr = sel_base + AW'(nxt_i);

  mem_bist_pattern #(.AW(AW), .DW(DW)) u_pattern (
    .mode (sel_mode),
    .seed (sel_seed),
    .idx  (DW'(nxt_i)),
    .addr (nxt_addr),
    .pat  (nxt_pat)
  );

  // Read data is only meaningful on the edge after a read was sampled.
  assign mismatch  = cmp_vld_q && (mem_rd_data != cmp_exp_q);
  assign err_upd   = err_count + (mismatch ? ONE_I : '0);
  assign first_upd = (mismatch && err_count == '0) ? cmp_addr_q : first_err_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    base_d        = base_q;
    len_d         = len_q;
    mode_d        = mode_q;
    seed_d        = seed_q;
    zero_pend_d   = 1'b0;
    cur_exp_d     = cur_exp_q;
    cmp_vld_d     = 1'b0;
    cmp_exp_d     = cmp_exp_q;
    cmp_addr_d    = cmp_addr_q;
    busy_d        = busy;
    done_d        = 1'b0;
    pass_d        = pass;
    err_d         = err_upd;
    first_d       = first_upd;
    mem_en_d      = mem_en;
    mem_wr_rd_d   = mem_wr_rd;
    mem_addr_d    = mem_addr;
    mem_wr_data_d = mem_wr_data;
    case (state_q)
      IDLE: begin
        if (zero_pend_q) begin
          done_d = 1'b1;
          pass_d = 1'b1;
        end else if (start) begin
          base_d  = base_addr;
          len_d   = len;
          mode_d  = mode;
          seed_d  = seed;
          err_d   = '0;
          first_d = '0;
          pass_d  = 1'b0;
          if (len == '0) begin
            zero_pend_d = 1'b1;
          end else begin
            state_d       = WRITE;
            busy_d        = 1'b1;
            idx_d         = '0;
            mem_en_d      = 1'b1;
            mem_wr_rd_d   = 1'b1;
            mem_addr_d    = nxt_addr;
            mem_wr_data_d = nxt_pat;
          end
        end
      end
      WRITE: begin
        idx_d      = nxt_i;
        mem_addr_d = nxt_addr;
        if (idx_last) begin
          state_d     = READ;
          mem_wr_rd_d = 1'b0;
          cur_exp_d   = nxt_pat;
        end else begin
          mem_wr_data_d = nxt_pat;
        end
      end
      READ: begin
        cmp_vld_d  = 1'b1;
        cmp_exp_d  = cur_exp_q;
        cmp_addr_d = mem_addr;
        if (idx_last) begin
          state_d     = DRAIN;
          mem_en_d    = 1'b0;
          mem_wr_rd_d = 1'b0;
        end else begin
          idx_d      = nxt_i;
          mem_addr_d = nxt_addr;
          cur_exp_d  = nxt_pat;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        idx_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_upd == '0);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q          <= '0;
      base_q         <= '0;
      len_q          <= '0;
      mode_q         <= '0;
      seed_q         <= '0;
      zero_pend_q    <= 1'b0;
      cur_exp_q      <= '0;
      cmp_vld_q      <= 1'b0;
      cmp_exp_q      <= '0;
      cmp_addr_q     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      mem_en         <= 1'b0;
      mem_wr_rd      <= 1'b0;
      mem_addr       <= '0;
      mem_wr_data    <= '0;
    end else begin
      idx_q          <= idx_d;
      base_q         <= base_d;
      len_q          <= len_d;
      mode_q         <= mode_d;
      seed_q         <= seed_d;
      zero_pend_q    <= zero_pend_d;
      cur_exp_q      <= cur_exp_d;
      cmp_vld_q      <= cmp_vld_d;
      cmp_exp_q      <= cmp_exp_d;
      cmp_addr_q     <= cmp_addr_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      err_count      <= err_d;
      first_err_addr <= first_d;
      mem_en         <= mem_en_d;
      mem_wr_rd      <= mem_wr_rd_d;
      mem_addr       <= mem_addr_d;
      mem_wr_data    <= mem_wr_data_d;
    end
  end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: 1-cycle-latency memory model with injectable read corruption,
// expected accesses and run results queued at start, checked by a monitor on the falling edge.
module tb_mem_bist_ctrl;
  import mem_bist_pkg::*;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic [1:0]    mode = '0;
  logic [DW-1:0] seed = '0;
  logic          busy, done, pass;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_addr;
  logic          mem_en, mem_wr_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;
  bist_state_t   dbg_state;

  logic [DW-1:0] mem_model [DEPTH];
  logic          corrupt [DEPTH];
  logic [63:0]   exp_q[$];
  logic [18:0]   acc_q[$];
  int n_chk = 0, n_fail = 0, n_done = 0, runs_issued = 0, cyc = 0;

  mem_bist_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .base_addr      (base_addr),
    .len            (len),
    .mode           (mode),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .mem_en         (mem_en),
    .mem_wr_rd      (mem_wr_rd),
    .mem_addr       (mem_addr),
    .mem_wr_data    (mem_wr_data),
    .mem_rd_data    (mem_rd_data),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected run to finish");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  always @(posedge clk) begin
    if (mem_en && mem_wr_rd) mem_model[mem_addr] <= mem_wr_data;
    if (mem_en && !mem_wr_rd)
      mem_rd_data <= mem_model[mem_addr] ^ (corrupt[mem_addr] ? 8'h40 : 8'h00);
    else
      mem_rd_data <= DW'($urandom);
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] pat_ref(input int m, input logic [7:0] s, input int i, input int a);
    case (m)
      0:       return s;
      1:       return 8'((int'(s) + i) % 256);
      2:       return 8'(a % 256) ^ s;
      default: return (i % 2 == 1) ? ~s : s;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic start_run(input logic [AW-1:0] b, input int n, input int m, input logic [DW-1:0] s);
    int err = 0;
    int first = 0;
    int a;
    int dc;
    for (int i = 0; i < n; i++) begin
      a = (int'(b) + i) % DEPTH;
      acc_q.push_back({1'b1, AW'(a), pat_ref(m, s, i, a)});
    end
    for (int i = 0; i < n; i++) begin
      a = (int'(b) + i) % DEPTH;
      acc_q.push_back({1'b0, AW'(a), 8'h00});
      if (corrupt[a]) begin
        if (err == 0) first = a;
        err++;
      end
    end
    dc = cyc + 1 + ((n == 0) ? 1 : 2 * n + 1);
    exp_q.push_back({32'(dc), 10'b0, (err == 0), 11'(err), 10'(first)});
    runs_issued++;
    base_addr = b;
    len       = 11'(n);
    mode      = 2'(m);
    seed      = s;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    base_addr = AW'($urandom);
    len       = 11'($urandom);
    mode      = 2'($urandom);
    seed      = DW'($urandom);
    chk("busy_after_start", 32'(busy), 32'(n != 0));
  endtask

  // Returns at the falling edge where done is high (or after the bound).
  task automatic wait_done(input int bound);
    int k = 0;
    while (!(done || n_done >= runs_issued) && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (!(done || n_done >= runs_issued)) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles, expected done pulse", bound);
    end
  endtask

  task automatic clear_corrupt();
    for (int i = 0; i < DEPTH; i++) corrupt[i] = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [18:0] a;
    logic [63:0] e;
    if (rst) begin
      if (mem_en) begin
        chk("busy_during_access", 32'(busy), 32'd1);
        if (acc_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_access: addr=0x%0h wr=%0d expected no access", mem_addr, mem_wr_rd);
        end else begin
          a = acc_q.pop_front();
          chk("access_dir", 32'(mem_wr_rd), 32'(a[18]));
          chk("access_addr", 32'(mem_addr), 32'(a[17:8]));
          if (a[18]) chk("write_data", 32'(mem_wr_data), 32'(a[7:0]));
        end
      end
      if (done) begin
        n_done++;
        chk("busy_at_done", 32'(busy), 32'd0);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: done pulse with no run outstanding, expected none");
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", 32'(cyc), e[63:32]);
          chk("pass", 32'(pass), 32'(e[21]));
          chk("err_count", 32'(err_count), 32'(e[20:10]));
          chk("first_err_addr", 32'(first_err_addr), 32'(e[9:0]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int nd, k, b, n, nc;
    clear_corrupt();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_first_err_addr", 32'(first_err_addr), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_wr_rd", 32'(mem_wr_rd), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wr_data", 32'(mem_wr_data), 0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;
    @(negedge clk);

    // Incrementing pattern from address 0.
    start_run(10'h000, 16, 1, 8'h10);
    wait_done(60);
    repeat (2) @(negedge clk);

    // Address-XOR pattern wrapping past the top of memory.
    start_run(10'h3FE, 4, 2, 8'hA5);
    wait_done(30);
    repeat (2) @(negedge clk);

    // Two corrupted reads.
    corrupt[10'h103] = 1'b1;
    corrupt[10'h106] = 1'b1;
    start_run(10'h100, 8, 0, 8'h3C);
    wait_done(40);
    clear_corrupt();
    repeat (2) @(negedge clk);

    // Zero-length run.
    start_run(10'h055, 0, 3, 8'h77);
    wait_done(10);
    repeat (2) @(negedge clk);

    // Start pulsed mid-run is ignored; then a start in the done cycle is accepted.
    start_run(10'h020, 12, 1, 8'h80);
    repeat (5) @(negedge clk);
    base_addr = 10'h300;
    len       = 11'd3;
    mode      = 2'd2;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(60);
    start_run(10'h040, 5, 3, 8'hC3);
    wait_done(30);
    repeat (2) @(negedge clk);

    // Reset in the middle of the read phase abandons the run.
    start_run(10'h180, 8, 1, 8'h01);
    k = 0;
    while (!(mem_en && !mem_wr_rd) && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("reached_read_phase", 32'(mem_en && !mem_wr_rd), 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrun_rst_mem_en", 32'(mem_en), 0);
    chk("midrun_rst_busy", 32'(busy), 0);
    chk("midrun_rst_done", 32'(done), 0);
    acc_q.delete();
    exp_q.delete();
    runs_issued = n_done;
    nd = n_done;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("no_done_after_reset", 32'(n_done), 32'(nd));
    start_run(10'h180, 8, 1, 8'h01);
    wait_done(40);
    repeat (2) @(negedge clk);

    // Randomized runs, some with corrupted reads, some back-to-back.
    for (int r = 0; r < 10; r++) begin
      b  = $urandom_range(0, DEPTH - 1);
      n  = $urandom_range(0, 40);
      nc = $urandom_range(0, 2);
      if (n > 0)
        for (int c = 0; c < nc; c++) corrupt[(b + $urandom_range(0, n - 1)) % DEPTH] = 1'b1;
      start_run(AW'(b), n, $urandom_range(0, 3), DW'($urandom));
      wait_done(2 * n + 20);
      clear_corrupt();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (2) @(negedge clk);

    // Full memory, checkerboard.
    start_run(10'h200, 1024, 3, 8'h55);
    wait_done(2100);
    repeat (3) @(negedge clk);

    chk("access_queue_empty", 32'(acc_q.size()), 0);
    chk("result_queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
